// File: rtl/tb_wb_pkg.sv
// Shared Wishbone command-master types: bus widths, response status codes and the queued command record.
package tb_wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        WB_OK      = 2'd0,
        WB_ERR     = 2'd1,
        WB_TIMEOUT = 2'd2
    } wb_status_e;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO of wb_cmd_t; head entry is visible combinationally while not empty.
module wb_cmd_fifo
    import tb_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clksys,
    input  logic    reset_n,
    input  logic    push,
    input  wb_cmd_t push_data,
    input  logic    pop,
    output wb_cmd_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    wb_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clksys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clksys) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle master fed by a command FIFO, returning one response per command.
// Optional bus timeout is built when WB_TIMEOUT_EN is defined.
module wb_cmd_master
    import tb_wb_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clksys,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic [1:0]          rsp_status,
    output logic                busy,
    output logic [WB_ADR_W-1:0] wishbone_adr,
    output logic [WB_DAT_W-1:0] wishbone_datwr,
    output logic [WB_SEL_W-1:0] wishbone_sel,
    output logic                wishbone_we,
    output logic                wishbone_cyc,
    output logic                wishbone_stb,
    output logic [2:0]          wishbone_cti,
    output logic [1:0]          wishbone_bte,
    input  logic [WB_DAT_W-1:0] wishbone_datrd,
    input  logic                wishbone_ack,
    input  logic                wishbone_err
);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e  state;
    wb_cmd_t cmd_in;
    wb_cmd_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;

    assign cmd_in = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};

    // A full FIFO still takes a command in the cycle its head is being popped.
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full || pop;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    assign wishbone_cti = 3'b000;
    assign wishbone_bte = 2'b00;

    wb_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clksys    (clksys),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef WB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge clksys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            wishbone_cyc   <= 1'b0;
            wishbone_stb   <= 1'b0;
            wishbone_adr   <= '0;
            wishbone_datwr <= '0;
            wishbone_sel   <= '0;
            wishbone_we    <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_dat        <= '0;
            rsp_status     <= WB_OK;
`ifdef WB_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        wishbone_adr   <= head.adr;
                        wishbone_datwr <= head.dat;
                        wishbone_sel   <= head.sel;
                        wishbone_we    <= head.we;
                        wishbone_cyc   <= 1'b1;
                        wishbone_stb   <= 1'b1;
`ifdef WB_TIMEOUT_EN
                        to_cnt         <= '0;
`endif
                        state          <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // err takes priority over a simultaneous ack
                    if (wishbone_err) begin
                        wishbone_cyc <= 1'b0;
                        wishbone_stb <= 1'b0;
                        rsp_dat      <= '0;
                        rsp_status   <= WB_ERR;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RESP;
                    end else if (wishbone_ack) begin
                        wishbone_cyc <= 1'b0;
                        wishbone_stb <= 1'b0;
                        rsp_dat      <= wishbone_we ? '0 : wishbone_datrd;
                        rsp_status   <= WB_OK;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RESP;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        wishbone_cyc <= 1'b0;
                        wishbone_stb <= 1'b0;
                        rsp_dat      <= '0;
                        rsp_status   <= WB_TIMEOUT;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: bus slave model plus command/response scoreboard queues.
`timescale 1ns/1ps
module tb_wb_cmd_master;
    import tb_wb_pkg::*;

    localparam int DEPTH  = 4;
    localparam int TO_CYC = 16;

    logic        clksys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [29:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [29:0] wishbone_adr;
    logic [31:0] wishbone_datwr;
    logic [3:0]  wishbone_sel;
    logic        wishbone_we, wishbone_cyc, wishbone_stb;
    logic [2:0]  wishbone_cti;
    logic [1:0]  wishbone_bte;
    logic [31:0] wishbone_datrd;
    logic        wishbone_ack, wishbone_err;

    always #5 clksys = ~clksys;

    wb_cmd_master #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clksys(clksys), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status), .busy(busy),
        .wishbone_adr(wishbone_adr), .wishbone_datwr(wishbone_datwr),
        .wishbone_sel(wishbone_sel), .wishbone_we(wishbone_we),
        .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb),
        .wishbone_cti(wishbone_cti), .wishbone_bte(wishbone_bte),
        .wishbone_datrd(wishbone_datrd), .wishbone_ack(wishbone_ack),
        .wishbone_err(wishbone_err)
    );

    // How the slave answers one bus cycle: respond in cycle 'delay' of cyc, or never.
    typedef struct {
        int          delay;
        bit          ack;
        bit          err;
        bit          never;
        logic [31:0] rdat;
    } plan_t;

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  status;
    } rsp_t;

    wb_cmd_t cmd_q[$];
    rsp_t    exp_q[$];
    plan_t   plan_q[$];

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;      // 0 random, 1 hold low, 2 hold high
    int ncyc = 0;
    int last_hs = -100;
    bit active = 0;
    int cyc_len = 0;
    plan_t   cur;
    wb_cmd_t seen;
    wb_cmd_t exp_c;
    rsp_t    exp_r;
    logic [31:0] rd_val;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic plan_t mk_plan(input int delay, input bit ack, input bit err,
                                      input bit never, input logic [31:0] rdat);
        plan_t p;
        p.delay = delay; p.ack = ack; p.err = err; p.never = never; p.rdat = rdat;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        int k;
        k = $urandom_range(0, 7);
        return mk_plan($urandom_range(1, 5), (k != 6), (k >= 6), 1'b0, $urandom);
    endfunction

    // Slave, cycle monitor and response checker, all evaluated at the falling edge.
    initial begin
        wishbone_ack = 0; wishbone_err = 0; wishbone_datrd = 0; rsp_ready = 0;
        forever begin
            @(negedge clksys);
            ncyc++;
            if (!reset_n) begin
                active = 0; wishbone_ack = 0; wishbone_err = 0; rsp_ready = 0;
                continue;
            end
            if (wishbone_cyc) begin
                if (!active) begin
                    active  = 1;
                    cyc_len = 1;
                    cur = (plan_q.size() > 0) ? plan_q.pop_front() : rand_plan();
                    seen = '{we: wishbone_we, adr: wishbone_adr, dat: wishbone_datwr, sel: wishbone_sel};
                    if (cmd_q.size() == 0) begin
                        check_eq("unexpected_cyc", 64'(wishbone_cyc), 64'(0));
                    end else begin
                        exp_c = cmd_q.pop_front();
                        check_eq("bus_adr_we_sel", 64'({seen.adr, seen.we, seen.sel}),
                                 64'({exp_c.adr, exp_c.we, exp_c.sel}));
                        check_eq("bus_datwr", 64'(seen.dat), 64'(exp_c.dat));
                    end
                    check_eq("stb_cti_bte", 64'({wishbone_stb, wishbone_cti, wishbone_bte}), 64'(6'b100000));
                    check_eq("gap_after_rsp", 64'(ncyc - last_hs >= 2), 64'(1));
                end else begin
                    cyc_len++;
                    check_eq("bus_stable", 64'({wishbone_stb, wishbone_we, wishbone_sel, wishbone_adr}),
                             64'({1'b1, seen.we, seen.sel, seen.adr}));
                    check_eq("bus_stable_dat", 64'(wishbone_datwr), 64'(seen.dat));
                end
                if (!cur.never && cyc_len == cur.delay) begin
                    rd_val = cur.rdat;
                    wishbone_ack = cur.ack;
                    wishbone_err = cur.err;
                    exp_r.status = cur.err ? 2'(WB_ERR) : 2'(WB_OK);
                    exp_r.dat    = (cur.err || seen.we) ? 32'h0 : rd_val;
                    exp_q.push_back(exp_r);
                end else begin
                    rd_val = $urandom;
                    wishbone_ack = 0;
                    wishbone_err = 0;
                end
                wishbone_datrd = rd_val;
            end else begin
                if (active) begin
                    active = 0;
                    check_eq("cyc_len", 64'(cyc_len), 64'(cur.never ? TO_CYC : cur.delay));
                    if (cur.never) begin
                        exp_r.status = 2'(WB_TIMEOUT);
                        exp_r.dat    = 32'h0;
                        exp_q.push_back(exp_r);
                    end
                end
                // stray handshakes while no cycle is open must be ignored
                wishbone_ack   = ($urandom_range(0, 3) == 0);
                wishbone_err   = ($urandom_range(0, 5) == 0);
                wishbone_datrd = $urandom;
            end
            case (rdy_mode)
                1:       rsp_ready = 0;
                2:       rsp_ready = 1;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    exp_r = exp_q.pop_front();
                    check_eq("rsp_status_dat", 64'({rsp_status, rsp_dat}), 64'({exp_r.status, exp_r.dat}));
                end
                last_hs = ncyc;
            end
        end
    end

    task automatic push_cmd(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        int waited = 0;
        @(negedge clksys);
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        while (!cmd_ready && waited < 300) begin
            @(negedge clksys);
            waited++;
        end
        if (!cmd_ready) begin
            check_eq("push_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 0;
            return;
        end
        cmd_q.push_back('{we: we, adr: adr, dat: dat, sel: sel});
        @(posedge clksys);
        #1;
        cmd_valid = 0;
    endtask

    task automatic push_rand();
        push_cmd($urandom_range(0, 1), 30'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((cmd_q.size() != 0 || exp_q.size() != 0 || busy || active) && n < 600) begin
            @(negedge clksys);
            n++;
        end
        check_eq({tag, "_drained"}, 64'({cmd_q.size() == 0, exp_q.size() == 0, busy}), 64'(3'b110));
        check_eq({tag, "_idle_outputs"}, 64'({rsp_valid, cmd_ready, wishbone_cyc}), 64'(3'b010));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        reset_n = 0;
        repeat (3) @(negedge clksys);
        check_eq("reset_ctrl", 64'({cmd_ready, rsp_valid, busy, wishbone_cyc, wishbone_stb, wishbone_we}),
                 64'(6'b100000));
        check_eq("reset_bus", 64'({wishbone_adr, wishbone_sel, wishbone_cti, wishbone_bte}), 64'(0));
        check_eq("reset_rsp", 64'({rsp_status, rsp_dat, wishbone_datwr == 32'h0}), 64'(1));
        #2 reset_n = 1;

        // 1: write, ack in third cycle of cyc, two-cycle latency from push
        rdy_mode = 2;
        plan_q.push_back(mk_plan(3, 1, 0, 0, 32'hA5A5A5A5));
        push_cmd(1, 30'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clksys);
        check_eq("latency_cyc_low", 64'(wishbone_cyc), 64'(0));
        @(negedge clksys);
        check_eq("latency_cyc_high", 64'(wishbone_cyc), 64'(1));
        wait_drain("t1_write");

        // 2: read returning a fixed word
        plan_q.push_back(mk_plan(1, 1, 0, 0, 32'h12345678));
        push_cmd(0, 30'h20, 32'h0, 4'hF);
        wait_drain("t2_read");

        // 3: one command parked in RESP plus DEPTH queued fills the FIFO
        rdy_mode = 1;
        for (int i = 0; i < DEPTH + 1; i++) push_rand();
        repeat (8) @(negedge clksys);
        check_eq("full_cmd_ready", 64'({cmd_ready, rsp_valid, busy}), 64'(3'b011));
        rdy_mode = 0;
        wait_drain("t3_queue");

        // 4: ack and err together
        rdy_mode = 2;
        plan_q.push_back(mk_plan(2, 1, 1, 0, 32'hCAFEF00D));
        push_cmd(0, 30'h44, 32'h0, 4'h3);
        wait_drain("t4_err");

`ifdef WB_TIMEOUT_EN
        // 5: slave never answers, next command still runs
        plan_q.push_back(mk_plan(0, 0, 0, 1, 32'h0));
        plan_q.push_back(mk_plan(2, 1, 0, 0, 32'h0BADBEEF));
        push_cmd(1, 30'h55, 32'h11112222, 4'hC);
        push_cmd(0, 30'h56, 32'h0, 4'hF);
        wait_drain("t5_timeout");
`endif

        // 6: reset while a cycle is open with two commands queued
        plan_q.push_back(mk_plan(0, 0, 0, 1, 32'h0));
        push_rand(); push_rand(); push_rand();
        n = 0;
        while (!wishbone_cyc && n < 50) begin
            @(negedge clksys);
            n++;
        end
        check_eq("t6_cyc_open", 64'(wishbone_cyc), 64'(1));
        #2 reset_n = 0;
        #1;
        check_eq("t6_async_drop", 64'({wishbone_cyc, wishbone_stb}), 64'(0));
        cmd_q.delete(); exp_q.delete(); plan_q.delete();
        repeat (2) @(negedge clksys);
        #2 reset_n = 1;
        @(negedge clksys);
        check_eq("t6_after_reset", 64'({busy, rsp_valid, cmd_ready, wishbone_cyc}), 64'(4'b0010));

        // 7: random traffic, random slave timing and response back-pressure
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            push_rand();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clksys);
        end
        wait_drain("t7_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
